// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one 32-bit memory backend between a 4-beat big-endian line fetch port and a data port.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  input  logic                  if_req,
  output logic [127:0]          if_rdata,
  output logic                  if_ack,
  input  logic [ADDR_WIDTH-1:0] data_addr,
  input  logic [31:0]           data_wdata,
  input  logic [1:0]            data_size,
  input  logic                  data_we,
  input  logic                  data_req,
  output logic [31:0]           data_rdata,
  output logic                  data_ack,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [1:0]            mem_size,
  output logic                  mem_we,
  output logic                  mem_req,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ack,
  output logic                  busy
);
  typedef enum logic [2:0] {IDLE, DATA, FETCH, RESP_D, RESP_I, DRAIN} state_t;
  state_t      state;
  logic [1:0]  beat;
  logic [3:0]  starve;
  logic        starved;
  logic [6:0]  lane;
  assign starved = if_req && (starve == 4'(STARVE_LIMIT));
  assign lane    = {~beat, 5'b0};
  assign busy    = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      beat       <= '0;
      starve     <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_size   <= '0;
      mem_we     <= 1'b0;
      mem_req    <= 1'b0;
      if_rdata   <= '0;
      data_rdata <= '0;
      if_ack     <= 1'b0;
      data_ack   <= 1'b0;
    end else begin
      case (state)
        IDLE:
          if (data_req && !starved) begin
            state     <= DATA;
            mem_req   <= 1'b1;
            mem_addr  <= data_addr;
            mem_wdata <= data_wdata;
            mem_size  <= data_size;
            mem_we    <= data_we;
            starve    <= if_req ? starve + 4'd1 : 4'd0;
          end else if (if_req) begin
            state    <= FETCH;
            beat     <= '0;
            mem_req  <= 1'b1;
            mem_addr <= if_addr;
            mem_size <= 2'b10;
            mem_we   <= 1'b0;
            starve   <= '0;
          end else
            starve <= '0;
        DATA:
          if (mem_ack) begin
            data_rdata <= mem_rdata;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            data_ack   <= 1'b1;
            state      <= RESP_D;
          end
        RESP_D: begin
          data_ack <= 1'b0;
          state    <= IDLE;
        end
        FETCH:
          // a dropped if_req abandons the burst; an ack already here needs no drain
          if (!if_req) begin
            if (mem_ack) begin
              mem_req <= 1'b0;
              state   <= IDLE;
            end else
              state <= DRAIN;
          end else if (mem_ack) begin
            if_rdata[lane +: 32] <= mem_rdata;
            if (beat == 2'd3) begin
              mem_req <= 1'b0;
              if_ack  <= 1'b1;
              state   <= RESP_I;
            end else begin
              beat     <= beat + 2'd1;
              mem_addr <= if_addr + ADDR_WIDTH'({beat + 2'd1, 2'b00});
            end
          end
        RESP_I: begin
          if_ack <= 1'b0;
          state  <= IDLE;
        end
        DRAIN:
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus randomized traffic against a byte-level memory reference model.
module tb_mem_port_arbiter;
  localparam int AW  = 32;
  localparam int LIM = 4;
  logic clk = 0;
  logic rst;
  logic [AW-1:0] if_addr, data_addr, mem_addr;
  logic if_req, if_ack, data_we, data_req, data_ack, mem_we, mem_req, mem_ack, busy;
  logic [127:0] if_rdata;
  logic [31:0] data_wdata, data_rdata, mem_wdata, mem_rdata;
  logic [1:0] data_size, mem_size;
  int total = 0, bad = 0;
  logic [7:0] mem [0:1][0:4095];
  int log_addr[$];
  byte order[$];
  bit zero_wait = 0, pending = 0;
  int wcnt = 0, if_acks = 0, d_acks = 0;
  always #5 clk = ~clk;
  mem_port_arbiter #(.ADDR_WIDTH(AW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .if_addr(if_addr), .if_req(if_req), .if_rdata(if_rdata), .if_ack(if_ack),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_size(data_size), .data_we(data_we),
    .data_req(data_req), .data_rdata(data_rdata), .data_ack(data_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_size(mem_size), .mem_we(mem_we),
    .mem_req(mem_req), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy)
  );
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] rd(input int k, input logic [31:0] a, input logic [1:0] s);
    logic [11:0] x = a[11:0];
    logic [31:0] w = {mem[k][x], mem[k][x+12'd1], mem[k][x+12'd2], mem[k][x+12'd3]};
    return s == 2'b00 ? {24'd0, w[31:24]} : s == 2'b01 ? {16'd0, w[31:16]} : w;
  endfunction
  task automatic wr(input int k, input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
    logic [11:0] x = a[11:0];
    if (s == 2'b00) mem[k][x] = d[7:0];
    else if (s == 2'b01) begin
      mem[k][x] = d[15:8];
      mem[k][x+12'd1] = d[7:0];
    end else
      for (int i = 0; i < 4; i++) mem[k][x+12'(i)] = d[31-8*i -: 8];
  endtask
  function automatic logic [127:0] line(input logic [31:0] a);
    return {rd(1, a, 2'b10), rd(1, a + 4, 2'b10), rd(1, a + 8, 2'b10), rd(1, a + 12, 2'b10)};
  endfunction
  // backend: big-endian byte memory, random or zero wait states, never acks during reset
  initial begin
    mem_ack = 0;
    mem_rdata = 0;
    forever begin
      @(negedge clk);
      mem_ack = 0;
      if (mem_req && !rst) begin
        if (!pending) begin
          pending = 1;
          wcnt = zero_wait ? 0 : int'($urandom_range(0, 2));
        end
        if (wcnt == 0) begin
          pending = 0;
          mem_ack = 1;
          log_addr.push_back(int'(mem_addr));
          if (mem_we) wr(0, mem_addr, mem_size, mem_wdata);
          mem_rdata = mem_we ? $urandom : rd(0, mem_addr, mem_size);
        end else
          wcnt--;
      end else
        pending = 0;
    end
  end
  always @(negedge clk) begin
    if (if_ack) if_acks++;
    if (data_ack) d_acks++;
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_fetch(input logic [31:0] a);
    int n = 0;
    if_addr = a;
    if_req = 1;
    do begin tick; n++; end while (!if_ack && n < 100);
    chk("fetch_done", n < 100, 1);
    if_req = 0;
    tick;
  endtask
  task automatic do_data(input logic [31:0] a, input logic [1:0] s, input bit we, input logic [31:0] w);
    int n = 0;
    data_addr = a;
    data_size = s;
    data_we = we;
    data_wdata = w;
    data_req = 1;
    do begin tick; n++; end while (!data_ack && n < 100);
    chk("data_done", n < 100, 1);
    if (we) wr(1, a, s, w);
    data_req = 0;
    tick;
  endtask
  task automatic issue_data;
    data_size = 2'($urandom_range(0, 2));
    data_addr = $urandom_range(0, 255) * 4 + (data_size == 2'b00 ? $urandom_range(0, 3) :
                data_size == 2'b01 ? 2 * $urandom_range(0, 1) : 0);
    data_we = 1'($urandom_range(0, 1));
    data_wdata = $urandom;
    data_req = 1;
  endtask
  task automatic run_mixed(input int n_ops, input bit hold);
    int issued = 0, cyc = 0, wait_d = 0;
    order.delete();
    while ((issued < n_ops || data_req || if_req) && cyc < 3000) begin
      tick;
      cyc++;
      if (data_ack) begin
        if (data_we) wr(1, data_addr, data_size, data_wdata);
        else chk("rand_load", data_rdata, rd(1, data_addr, data_size));
        order.push_back("D");
        data_req = 0;
        if (if_req) wait_d++;
      end
      if (if_ack) begin
        chk("rand_line", if_rdata, line(if_addr));
        chk("starve_bound", wait_d <= LIM + 1, 1);
        order.push_back("F");
        if_req = 0;
        wait_d = 0;
      end
      if (!data_req && issued < n_ops && (hold || $urandom_range(0, 2) == 0)) begin
        issue_data;
        issued++;
      end
      if (!if_req && issued < n_ops && (hold || $urandom_range(0, 3) == 0)) begin
        if_addr = $urandom_range(0, 255) * 4;
        if_req = 1;
        issued++;
      end
    end
    chk("mixed_done", cyc < 3000, 1);
    tick;
  endtask
  initial begin
    logic [127:0] pat = 128'h00090100_05020902_01001200_00000000;
    int n, k0, c;
    byte e;
    rst = 1; if_req = 0; data_req = 0; if_addr = 0; data_addr = 0;
    data_wdata = 0; data_size = 0; data_we = 0;
    for (int i = 0; i < 4096; i++) begin
      mem[0][i] = 8'($urandom);
      mem[1][i] = mem[0][i];
    end
    for (int i = 0; i < 16; i++) begin
      mem[0][i] = pat[127-8*i -: 8];
      mem[1][i] = pat[127-8*i -: 8];
    end
    repeat (3) tick;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_acks", {if_ack, data_ack}, 0);
    chk("rst_rdata", {if_rdata, data_rdata}, 0);
    rst = 0;
    tick;
    log_addr.delete();
    do_fetch(0);
    repeat (2) tick;
    chk("fetch_beats", log_addr.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("beat%0d_addr", i), log_addr[i], 4 * i);
    chk("fetch_line", if_rdata, pat);
    chk("fetch_ack_once", if_acks, 1);
    do_data(32'h100, 2'b10, 1, 32'hDEADBEEF);
    do_data(32'h101, 2'b00, 0, 0);
    chk("load_byte", data_rdata[7:0], 8'hAD);
    repeat (3) tick;
    chk("data_ack_once", d_acks, 2);
    zero_wait = 1;
    data_addr = 32'h100; data_size = 2'b10; data_we = 0; data_req = 1; n = 0;
    do begin tick; n++; end while (!data_ack && n < 20);
    data_req = 0;
    chk("data_latency", n + 1, 3);
    chk("lat_load", data_rdata, 32'hDEADBEEF);
    repeat (2) tick;
    if_addr = 32'h40; if_req = 1; n = 0;
    do begin tick; n++; end while (!if_ack && n < 20);
    if_req = 0;
    chk("fetch_latency", n + 1, 6);
    chk("lat_line", if_rdata, line(32'h40));
    zero_wait = 0;
    repeat (2) tick;
    run_mixed(10, 1);
    chk("grant_count", order.size(), 10);
    c = 0;
    for (int i = 0; i < 10; i++) begin
      if (c == LIM) begin e = "F"; c = 0; end
      else begin e = "D"; c++; end
      chk($sformatf("grant%0d", i), order[i], e);
    end
    repeat (2) tick;
    log_addr.delete();
    k0 = if_acks;
    if_addr = 32'h200; if_req = 1; n = 0;
    while (log_addr.size() < 2 && n < 100) begin tick; n++; end
    if_req = 0;
    data_addr = 32'h104; data_size = 2'b10; data_we = 0; data_req = 1; n = 0;
    do begin tick; n++; end while (!data_ack && n < 100);
    data_req = 0;
    chk("abort_load", data_rdata, rd(1, 32'h104, 2'b10));
    tick;
    chk("abort_busy", busy, 0);
    chk("abort_accesses", log_addr.size(), 4);
    chk("abort_beat2", log_addr[2], 32'h208);
    chk("abort_then_data", log_addr[3], 32'h104);
    chk("abort_no_if_ack", if_acks, k0);
    log_addr.delete();
    if_addr = 32'h300; if_req = 1; n = 0;
    while (log_addr.size() < 2 && n < 100) begin tick; n++; end
    rst = 1;
    tick;
    chk("midrst_mem_req", mem_req, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_if_ack", if_ack, 0);
    rst = 0;
    log_addr.delete();
    n = 0;
    do begin tick; n++; end while (!if_ack && n < 100);
    chk("restart_beat0", log_addr[0], 32'h300);
    chk("restart_line", if_rdata, line(32'h300));
    if_req = 0;
    repeat (2) tick;
    run_mixed(120, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
